// File: rtl/cc_matrix_scan_pkg.sv
// Shared types and constants for the 8x8 LED matrix row scanner.
package cc_matrix_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam int         ROW_COUNT = 8;
  localparam logic [2:0] FIRST_ROW = 3'd7;

endpackage

// File: rtl/cc_scan_prescaler.sv
// Loadable down-counter with sync clear; tc_o pulses while enabled at zero.
// The owner reloads it on tc_o, so one instance times both lit rows and blanking.
module cc_scan_prescaler #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/cc_matrix_scan.sv
// Row-multiplexed 8x8 LED driver with tear-free frame promotion at the frame wrap.
// Optional blanking between rows when CC_MATRIX_SCAN_BLANK_EN is defined.
module cc_matrix_scan
  import cc_matrix_scan_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       matrix_scan_CLOCK_50,
  input  logic       matrix_scan_RESET_InHigh,
  input  logic [7:0] matrix_scan_fila7_bus_in,
  input  logic [7:0] matrix_scan_fila6_bus_in,
  input  logic [7:0] matrix_scan_fila5_bus_in,
  input  logic [7:0] matrix_scan_fila4_bus_in,
  input  logic [7:0] matrix_scan_fila3_bus_in,
  input  logic [7:0] matrix_scan_fila2_bus_in,
  input  logic [7:0] matrix_scan_fila1_bus_in,
  input  logic [7:0] matrix_scan_fila0_bus_in,
  input  logic       matrix_scan_load_In,
  input  logic       matrix_scan_enable_In,
  output logic [7:0] matrix_scan_row_bus_out,
  output logic [7:0] matrix_scan_col_bus_out,
  output logic       matrix_scan_frame_done_out,
  output logic       matrix_scan_pending_out
);

  // Counter is sized for the longer of the two intervals it may time.
  localparam int PW = (CLK_DIV > BLANK_CYCLES) ? $clog2(CLK_DIV) : $clog2(BLANK_CYCLES);
  localparam logic [PW-1:0] ROW_LOAD = PW'(CLK_DIV - 1);
`ifdef CC_MATRIX_SCAN_BLANK_EN
  localparam logic [PW-1:0] BLANK_LOAD = PW'(BLANK_CYCLES - 1);
`endif

  scan_state_e                  state_q, state_d;
  logic [2:0]                   row_q, row_d;
  logic [ROW_COUNT-1:0][7:0]    active_q, active_d, pending_q, pending_d, in_frame;
  logic                         pvld_q, pvld_d;
  logic [7:0]                   row_bus_q, row_bus_d, col_q, col_d;
  logic                         fd_q, wrap;
  logic                         pre_clr, pre_load, pre_en, pre_tc;
  logic [PW-1:0]                pre_val;

  assign in_frame = {matrix_scan_fila7_bus_in, matrix_scan_fila6_bus_in,
                     matrix_scan_fila5_bus_in, matrix_scan_fila4_bus_in,
                     matrix_scan_fila3_bus_in, matrix_scan_fila2_bus_in,
                     matrix_scan_fila1_bus_in, matrix_scan_fila0_bus_in};

  cc_scan_prescaler #(.W(PW)) u_prescaler (
    .clk_i      (matrix_scan_CLOCK_50),
    .rst_i      (matrix_scan_RESET_InHigh),
    .clr_i      (pre_clr),
    .load_i     (pre_load),
    .load_val_i (pre_val),
    .en_i       (pre_en),
    .tc_o       (pre_tc)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    pre_clr  = 1'b0;
    pre_load = 1'b0;
    pre_en   = 1'b0;
    pre_val  = ROW_LOAD;
    wrap     = 1'b0;
    case (state_q)
      IDLE: begin
        row_d   = FIRST_ROW;
        pre_clr = 1'b1;
        if (matrix_scan_enable_In) begin
          state_d  = SCAN;
          pre_clr  = 1'b0;
          pre_load = 1'b1;
        end
      end
      SCAN: begin
        pre_en = 1'b1;
        if (pre_tc) begin
          pre_load = 1'b1;
`ifdef CC_MATRIX_SCAN_BLANK_EN
          state_d = BLANK;
          pre_val = BLANK_LOAD;
`else
          row_d = row_q - 3'd1;
          wrap  = (row_q == 3'd0);
`endif
        end
      end
`ifdef CC_MATRIX_SCAN_BLANK_EN
      BLANK: begin
        pre_en = 1'b1;
        if (pre_tc) begin
          state_d  = SCAN;
          pre_load = 1'b1;
          row_d    = row_q - 3'd1;
          wrap     = (row_q == 3'd0);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Dropping enable wins over everything and forfeits any pending wrap.
    if (!matrix_scan_enable_In) begin
      state_d  = IDLE;
      row_d    = FIRST_ROW;
      wrap     = 1'b0;
      pre_load = 1'b0;
      pre_clr  = 1'b1;
    end
  end

  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pvld_d    = pvld_q;
    if (matrix_scan_load_In && (state_q == IDLE)) begin
      active_d = in_frame;
    end else if (wrap) begin
      pvld_d = 1'b0;
      if (matrix_scan_load_In) begin
        active_d = in_frame;
      end else if (pvld_q) begin
        active_d = pending_q;
      end
    end else if (matrix_scan_load_In) begin
      pending_d = in_frame;
      pvld_d    = 1'b1;
    end
  end

  // Outputs are registered from next-state so they line up with the lit row.
  always_comb begin
    row_bus_d = 8'd0;
    col_d     = 8'd0;
    if (state_d == SCAN) begin
      row_bus_d = 8'd1 << row_d;
      col_d     = active_d[row_d];
    end
  end

  always_ff @(posedge matrix_scan_CLOCK_50) begin
    if (matrix_scan_RESET_InHigh) begin
      state_q   <= IDLE;
      row_q     <= FIRST_ROW;
      active_q  <= '0;
      pending_q <= '0;
      pvld_q    <= 1'b0;
      row_bus_q <= 8'd0;
      col_q     <= 8'd0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pvld_q    <= pvld_d;
      row_bus_q <= row_bus_d;
      col_q     <= col_d;
      fd_q      <= wrap;
    end
  end

  assign matrix_scan_row_bus_out    = row_bus_q;
  assign matrix_scan_col_bus_out    = col_q;
  assign matrix_scan_frame_done_out = fd_q;
  assign matrix_scan_pending_out    = pvld_q;

endmodule

// File: tb/tb_cc_matrix_scan.sv
// Scoreboard bench for cc_matrix_scan: time-based reference model feeds an expected queue.
module tb_cc_matrix_scan;

  localparam int CLK_DIV      = 4;
  localparam int BLANK_CYCLES = 2;
`ifdef CC_MATRIX_SCAN_BLANK_EN
  localparam int ROWP = CLK_DIV + BLANK_CYCLES;
`else
  localparam int ROWP = CLK_DIV;
`endif
  localparam int FRAMEP = 8 * ROWP;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       fd;
    logic       pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic [7:0] rows [8];
  logic [7:0] row_bus, col_bus;
  logic       frame_done, pending;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: scan position is just elapsed cycles since start.
  bit         m_on = 1'b0;
  int         m_t = 0;
  logic [7:0] m_active [8];
  logic [7:0] m_pend [8];
  bit         m_pvld = 1'b0;

  always #5 clk = ~clk;

  cc_matrix_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .matrix_scan_CLOCK_50       (clk),
    .matrix_scan_RESET_InHigh   (rst),
    .matrix_scan_fila7_bus_in   (rows[7]),
    .matrix_scan_fila6_bus_in   (rows[6]),
    .matrix_scan_fila5_bus_in   (rows[5]),
    .matrix_scan_fila4_bus_in   (rows[4]),
    .matrix_scan_fila3_bus_in   (rows[3]),
    .matrix_scan_fila2_bus_in   (rows[2]),
    .matrix_scan_fila1_bus_in   (rows[1]),
    .matrix_scan_fila0_bus_in   (rows[0]),
    .matrix_scan_load_In        (load),
    .matrix_scan_enable_In      (en),
    .matrix_scan_row_bus_out    (row_bus),
    .matrix_scan_col_bus_out    (col_bus),
    .matrix_scan_frame_done_out (frame_done),
    .matrix_scan_pending_out    (pending)
  );

  function automatic int mrow();
    return 7 - ((m_t / ROWP) % 8);
  endfunction

  task automatic model_step();
    exp_t e;
    bit   wrap;
    e = '0;
    if (rst) begin
      m_on = 1'b0; m_t = 0; m_pvld = 1'b0;
      for (int i = 0; i < 8; i++) begin m_active[i] = 8'h00; m_pend[i] = 8'h00; end
    end else begin
      wrap = m_on && en && (m_t == FRAMEP - 1);
      if (load && !m_on) begin
        for (int i = 0; i < 8; i++) m_active[i] = rows[i];
      end else if (wrap) begin
        if (load) for (int i = 0; i < 8; i++) m_active[i] = rows[i];
        else if (m_pvld) for (int i = 0; i < 8; i++) m_active[i] = m_pend[i];
        m_pvld = 1'b0;
      end else if (load) begin
        for (int i = 0; i < 8; i++) m_pend[i] = rows[i];
        m_pvld = 1'b1;
      end
      if (!en) begin
        m_on = 1'b0;
      end else if (!m_on) begin
        m_on = 1'b1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAMEP;
      end
      if (m_on && ((m_t % ROWP) < CLK_DIV)) begin
        e.row = 8'd1 << mrow();
        e.col = m_active[mrow()];
      end
      e.fd   = wrap;
    end
    e.pend = m_pvld;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_rows(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rows[i] = v;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("row_bus", row_bus, e.row);
      check("col_bus", col_bus, e.col);
      check("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
      check("pending", {7'd0, pending}, {7'd0, e.pend});
    end
  end

  task automatic wait_row(input int r);
    int n = 0;
    while (!(m_on && mrow() == r && (m_t % ROWP) == 0) && n < 200) begin cyc(); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL wait_row %0d: model never reached row", r);
    end
  endtask

  initial begin
    set_rows(8'h00);
    // Reset then idle with enable low.
    cyc();
    rst = 1'b0;
    run(10);
    // Load in IDLE, then start.
    rows[7] = 8'hFF; rows[6] = 8'h7E; load = 1'b1;
    cyc();
    load = 1'b0; en = 1'b1;
    run(40);
    // Active all 18h, load A5h while row 4 lit.
    en = 1'b0; cyc();
    set_rows(8'h18); load = 1'b1; cyc();
    load = 1'b0; en = 1'b1;
    wait_row(4);
    set_rows(8'hA5); load = 1'b1; cyc();
    load = 1'b0;
    run(40);
    // Pending A5h overwritten by a boundary-cycle load of 3Ch.
    wait_row(5);
    set_rows(8'hA5); load = 1'b1; cyc();
    load = 1'b0;
    begin
      int n = 0;
      while (m_t != FRAMEP - 1 && n < 200) begin cyc(); n++; end
    end
    set_rows(8'h3C); load = 1'b1; cyc();
    load = 1'b0;
    run(40);
    // Drop enable during row 5, keep a pending frame across the pause.
    wait_row(5);
    set_rows(8'h99); load = 1'b1; cyc();
    load = 1'b0; en = 1'b0;
    run(3);
    en = 1'b1;
    run(45);
    // Reset in mid-scan with load and enable high.
    load = 1'b1; rst = 1'b1; cyc();
    rst = 1'b0; load = 1'b0;
    run(20);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 99) < 97);
      load = ($urandom_range(0, 24) == 0);
      for (int j = 0; j < 8; j++) rows[j] = 8'($urandom);
      cyc();
    end
    rst = 1'b0; load = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
